// File: rtl/edge_threshold_framer.sv
// Pixel framer: 2-entry skid buffer with frame position tracking and tlast/frame-done generation.
// Optional binarisation against a per-frame latched threshold when EDGE_THRESHOLD_EN is defined.
module edge_threshold_framer #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic       axi_clk,
    input  logic       axi_rst,
    input  logic       i_data_valid,
    input  logic [7:0] i_data,
    output logic       o_data_ready,
    input  logic [7:0] i_threshold,
    output logic       o_data_valid,
    output logic [7:0] o_data,
    output logic       o_data_last,
    input  logic       i_data_ready,
    output logic       o_frame_done
);

    localparam logic [11:0] COL_MAX = 12'(IMG_WIDTH - 1);
    localparam logic [11:0] ROW_MAX = 12'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  ent0_data_q, ent0_data_d;
    logic        ent0_last_q, ent0_last_d;
    logic [7:0]  ent1_data_q, ent1_data_d;
    logic        ent1_last_q, ent1_last_d;
    logic [1:0]  count_q, count_d;
    logic        ready_q, ready_d;
    logic [11:0] col_q, col_d;
    logic [11:0] row_q, row_d;

    logic        push, pop, first_px, last_px;
    logic [7:0]  new_data;

    assign push     = i_data_valid & ready_q;
    assign pop      = (count_q != 2'd0) & i_data_ready;
    assign first_px = (col_q == 12'd0) && (row_q == 12'd0);
    assign last_px  = (col_q == COL_MAX) && (row_q == ROW_MAX);

`ifdef EDGE_THRESHOLD_EN
    logic [7:0] thr_q, thr_d, thr_eff;

    // The first pixel of a frame is compared against the value being latched on that edge.
    assign thr_eff  = first_px ? i_threshold : thr_q;
    assign new_data = (i_data >= thr_eff) ? 8'hFF : 8'h00;

    always_comb begin
        thr_d = thr_q;
        if (push && first_px) begin
            thr_d = i_threshold;
        end
    end

    always_ff @(posedge axi_clk or negedge axi_rst) begin
        if (!axi_rst) begin
            thr_q <= 8'd0;
        end else begin
            thr_q <= thr_d;
        end
    end
`else
    logic unused_thr;
    assign unused_thr = ^i_threshold;
    assign new_data   = i_data;
`endif

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (push) begin
            if (col_q == COL_MAX) begin
                col_d = 12'd0;
                row_d = (row_q == ROW_MAX) ? 12'd0 : row_q + 12'd1;
            end else begin
                col_d = col_q + 12'd1;
            end
        end
    end

    // Entry 0 is always the head and drives the output directly.
    always_comb begin
        ent0_data_d = ent0_data_q;
        ent0_last_d = ent0_last_q;
        ent1_data_d = ent1_data_q;
        ent1_last_d = ent1_last_q;
        count_d     = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    ent0_data_d = new_data;
                    ent0_last_d = last_px;
                end else begin
                    ent1_data_d = new_data;
                    ent1_last_d = last_px;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                ent0_data_d = ent1_data_q;
                ent0_last_d = ent1_last_q;
                count_d     = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    ent0_data_d = new_data;
                    ent0_last_d = last_px;
                end else begin
                    ent0_data_d = ent1_data_q;
                    ent0_last_d = ent1_last_q;
                    ent1_data_d = new_data;
                    ent1_last_d = last_px;
                end
            end
            default: ;
        endcase
        ready_d = (count_d != 2'd2);
    end

    always_comb begin
        state_d = state_q;
        if (pop && ent0_last_q) begin
            state_d = S_DONE;
        end else begin
            case (state_q)
                S_IDLE:   if (push) state_d = S_ACTIVE;
                S_ACTIVE: state_d = S_ACTIVE;
                S_DONE:   state_d = push ? S_ACTIVE : S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge axi_clk or negedge axi_rst) begin
        if (!axi_rst) begin
            state_q     <= S_IDLE;
            ent0_data_q <= 8'd0;
            ent0_last_q <= 1'b0;
            ent1_data_q <= 8'd0;
            ent1_last_q <= 1'b0;
            count_q     <= 2'd0;
            ready_q     <= 1'b0;
            col_q       <= 12'd0;
            row_q       <= 12'd0;
        end else begin
            state_q     <= state_d;
            ent0_data_q <= ent0_data_d;
            ent0_last_q <= ent0_last_d;
            ent1_data_q <= ent1_data_d;
            ent1_last_q <= ent1_last_d;
            count_q     <= count_d;
            ready_q     <= ready_d;
            col_q       <= col_d;
            row_q       <= row_d;
        end
    end

    assign o_data_ready = ready_q;
    assign o_data_valid = (count_q != 2'd0);
    assign o_data       = ent0_data_q;
    assign o_data_last  = ent0_last_q;
    assign o_frame_done = (state_q == S_DONE);

endmodule

// File: doc/edge_threshold_framer.md
EDGE_THRESHOLD_FRAMER -- requirements
Module: edge_threshold_framer

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 512, pixels per line (2..4096).
REQ-002 SHALL have parameter IMG_HEIGHT, default 512, lines per frame (1..4096).
REQ-003 SHALL have port axi_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port axi_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_data_valid  input  1  upstream (convolver output) pixel valid.
REQ-006 SHALL have port i_data  input  8  upstream convolved pixel.
REQ-007 SHALL have port o_data_ready  output  1  accept indication to upstream.
REQ-008 SHALL have port i_threshold  input  8  binarisation threshold, quasi-static.
REQ-009 SHALL have port o_data_valid  output  1  downstream pixel valid.
REQ-010 SHALL have port o_data  output  8  processed pixel.
REQ-011 SHALL have port o_data_last  output  1  marks last pixel of frame (AXI-stream tlast).
REQ-012 SHALL have port i_data_ready  input  1  downstream accept.
REQ-013 SHALL have port o_frame_done  output  1  one-cycle pulse after last pixel of frame leaves.

Function
REQ-014 Input handshake SHALL occur when i_data_valid and o_data_ready are both high in a cycle; output handshake when o_data_valid and i_data_ready are both high.
REQ-015 Block SHALL hold a 2-entry skid buffer (data + last flag); o_data_ready SHALL be a registered signal, high iff fewer than 2 entries are held after the current cycle's updates.
REQ-016 With buffer empty and i_data_ready high, a pixel accepted in cycle N SHALL appear on o_data in cycle N+1 (latency 1).
REQ-017 Simultaneous push and pop SHALL keep occupancy unchanged; order SHALL be strictly FIFO; no pixel dropped or duplicated.
REQ-018 o_data, o_data_last SHALL stay stable while o_data_valid is high and i_data_ready is low.
REQ-019 Column counter (0..IMG_WIDTH-1) and row counter (0..IMG_HEIGHT-1) SHALL advance on each input handshake; column wraps to 0 and row increments at IMG_WIDTH-1; both wrap to 0 after the pixel at (IMG_WIDTH-1, IMG_HEIGHT-1).
REQ-020 last flag SHALL be set only on the pixel accepted at (IMG_WIDTH-1, IMG_HEIGHT-1).
REQ-021 FSM states: IDLE, ACTIVE, DONE.
REQ-022 IDLE->ACTIVE on first input handshake; i_threshold SHALL be latched into an internal register on that same edge and held for the whole frame.
REQ-023 ACTIVE->DONE on the output handshake of the pixel carrying last; DONE->IDLE unconditionally next cycle; o_frame_done SHALL be high exactly in the DONE cycle.
REQ-024 A new frame's first pixel MAY be accepted while in DONE; it SHALL be counted as (0,0) and cause DONE->ACTIVE with threshold latch instead of DONE->IDLE.

Reset
REQ-025 On axi_rst low, asynchronously: o_data_valid=0, o_data=0, o_data_last=0, o_frame_done=0, o_data_ready=0, buffer empty, counters 0, latched threshold 0, FSM=IDLE.
REQ-026 o_data_ready SHALL rise on the first clock edge after axi_rst deasserts; reset mid-frame SHALL discard buffered pixels and the partial frame with no o_frame_done pulse.

Configuration
REQ-027 Macro EDGE_THRESHOLD_EN defined: output pixel SHALL be 8'hFF if stored pixel >= latched threshold, else 8'h00 (comparison applied at input handshake).
REQ-028 Macro EDGE_THRESHOLD_EN undefined: output pixel SHALL equal input pixel unmodified; i_threshold ignored; threshold register not built.

Verification
REQ-029 Thresh=100, macro on, pixels 99,100,255 with i_data_ready=1 -> outputs 00,FF,FF each one cycle after acceptance.
REQ-030 IMG_WIDTH=4, IMG_HEIGHT=2, 8 continuous pixels -> o_data_last high only on 8th output; o_frame_done pulses one cycle after its handshake.
REQ-031 i_data_ready=0 for 5 cycles with source always valid -> o_data_ready low after 2 accepted, o_data stable; on release all pixels out in order, none lost.
REQ-032 Change i_threshold from 100 to 200 mid-frame -> current frame uses 100; next frame uses 200.
REQ-033 Assert axi_rst after 3 of 8 pixels -> all outputs 0 immediately; next 8 pixels form a full frame, last on 8th.
